// File: rtl/serial_accum_ctrl_if.sv
// Bus between the serial accumulator controller and its surroundings:
// board buttons and adder carry in, datapath strobes and status LEDs out.
interface serial_accum_ctrl_if #(
  parameter int N  = 8,
  parameter int CH = 2,
  parameter int CW = 4
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int BW  = $clog2(N);

  logic           load_btn;
  logic           stop_btn;
  logic [CHW-1:0] ch_sel_in;
  logic           carry_in;
  logic [CHW-1:0] ch_sel;
  logic           clear_acc;
  logic           load_input;
  logic           shift_en;
  logic [BW-1:0]  bit_idx;
  logic [CW-1:0]  op_count;
  logic           ready_led;
  logic           done_led;
  logic           ovf_led;

  // Board/datapath side: drives buttons and carry, observes controller outputs.
  modport master (
    output load_btn, stop_btn, ch_sel_in, carry_in,
    input  ch_sel, clear_acc, load_input, shift_en, bit_idx, op_count,
           ready_led, done_led, ovf_led
  );

  // Controller side.
  modport slave (
    input  load_btn, stop_btn, ch_sel_in, carry_in,
    output ch_sel, clear_acc, load_input, shift_en, bit_idx, op_count,
           ready_led, done_led, ovf_led
  );
endinterface

// File: rtl/serial_accum_ctrl.sv
// Multi-channel sequencer for a bit-serial accumulator: staged clear,
// operand load, N-cycle serial add, per-channel operand count and sticky
// overflow. All outputs are decoded from registered state (Moore).
module serial_accum_ctrl #(
  parameter int N       = 8,
  parameter int CH      = 2,
  parameter int MAX_OPS = 15,
  parameter int CW      = 4
) (
  input logic                clk,
  input logic                reset,
  serial_accum_ctrl_if.slave bus
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int BW  = $clog2(N);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_READY = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CHW-1:0] K_LAST = CHW'(CH - 1);
  localparam logic [BW-1:0]  B_LAST = BW'(N - 1);
  localparam logic [CW-1:0]  C_MAX  = CW'(MAX_OPS);

  logic [2:0]     state_q, state_d;
  logic [CHW-1:0] k_q, k_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [CW-1:0]  cnt_q [CH];
  logic [CW-1:0]  cnt_d [CH];
  logic [CH-1:0]  ovf_q, ovf_d;
  logic           load_prev_q, stop_prev_q;

  logic           load_edge, stop_edge;
  logic [CHW-1:0] tgt;
  logic           tgt_full;
  logic [CW-1:0]  inc_cnt;
  logic [CHW-1:0] sel;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign load_edge = bus.load_btn & ~load_prev_q;
  assign stop_edge = bus.stop_btn & ~stop_prev_q;

  // Out-of-range channel requests fall back to channel 0.
  assign tgt      = (int'(bus.ch_sel_in) < CH) ? bus.ch_sel_in : '0;
  assign tgt_full = (cnt_q[tgt] >= C_MAX);
  assign inc_cnt  = sat_inc(cnt_q[ch_q]);

  // Next-state logic; button edges outside IDLE/READY/DONE simply fall through.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d[k_q] = '0;
        ovf_d[k_q] = 1'b0;
        if (k_q == K_LAST) begin
          state_d = S_IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (load_edge && !tgt_full) begin
          state_d = S_LOAD;
          ch_d    = tgt;
        end
      end
      S_LOAD: begin
        state_d = S_ADD;
        bit_d   = '0;
      end
      S_ADD: begin
        if (bit_q == B_LAST) begin
          bit_d = '0;
          if (bus.carry_in) ovf_d[ch_q] = 1'b1;
          cnt_d[ch_q] = inc_cnt;
          state_d     = (inc_cnt == C_MAX) ? S_DONE : S_READY;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_READY: begin
        // A load edge takes priority even when it is refused for a full channel.
        if (load_edge) begin
          if (!tgt_full) begin
            state_d = S_LOAD;
            ch_d    = tgt;
          end
        end else if (stop_edge) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (stop_edge) begin
          state_d = S_CLEAR;
          k_d     = '0;
        end else if (load_edge) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_CLEAR;
        k_d     = '0;
      end
    endcase
  end

  // State, counters and button history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CLEAR;
      k_q         <= '0;
      ch_q        <= '0;
      bit_q       <= '0;
      cnt_q       <= '{default: '0};
      ovf_q       <= '0;
      load_prev_q <= 1'b0;
      stop_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ch_q        <= ch_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      load_prev_q <= bus.load_btn;
      stop_prev_q <= bus.stop_btn;
    end
  end

  assign sel            = (state_q == S_CLEAR) ? k_q : ch_q;
  assign bus.ch_sel     = sel;
  assign bus.clear_acc  = (state_q == S_CLEAR);
  assign bus.load_input = (state_q == S_LOAD);
  assign bus.shift_en   = (state_q == S_ADD);
  assign bus.bit_idx    = (state_q == S_ADD) ? bit_q : '0;
  assign bus.op_count   = cnt_q[sel];
  assign bus.ovf_led    = ovf_q[sel];
  assign bus.ready_led  = (state_q == S_READY);
  assign bus.done_led   = (state_q == S_DONE);
endmodule

// File: tb/tb_serial_accum_ctrl.sv
// Bench for serial_accum_ctrl: directed scenarios plus random button
// traffic, checked against a transaction-level model of channel counts,
// overflow flags and the controller's visible mode.
module tb_serial_accum_ctrl;
  localparam int N       = 8;
  localparam int CH      = 2;
  localparam int MAX_OPS = 3;
  localparam int CW      = 4;
  localparam int CHW     = (CH > 1) ? $clog2(CH) : 1;

  typedef enum {M_CLEAR, M_IDLE, M_READY, M_DONE} mode_t;

  logic clk = 1'b0;
  logic reset;

  serial_accum_ctrl_if #(.N(N), .CH(CH), .CW(CW)) bus ();

  serial_accum_ctrl #(.N(N), .CH(CH), .MAX_OPS(MAX_OPS), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    mcnt [CH];
  bit    movf [CH];
  int    msel;
  mode_t mode;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_zero();
    for (int i = 0; i < CH; i++) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".clear_acc"}, 32'(bus.clear_acc), 32'(1));
    chk({tag, ".ch_sel"},    32'(bus.ch_sel), 32'(0));
    chk({tag, ".load"},      32'(bus.load_input), 32'(0));
    chk({tag, ".shift"},     32'(bus.shift_en), 32'(0));
    chk({tag, ".bit_idx"},   32'(bus.bit_idx), 32'(0));
    chk({tag, ".op_count"},  32'(bus.op_count), 32'(0));
    chk({tag, ".ready"},     32'(bus.ready_led), 32'(0));
    chk({tag, ".done"},      32'(bus.done_led), 32'(0));
    chk({tag, ".ovf"},       32'(bus.ovf_led), 32'(0));
  endtask

  // Settled-mode outputs expected in IDLE, READY or DONE.
  task automatic check_status(input string tag);
    chk({tag, ".clear_acc"}, 32'(bus.clear_acc), 32'(0));
    chk({tag, ".load"},      32'(bus.load_input), 32'(0));
    chk({tag, ".shift"},     32'(bus.shift_en), 32'(0));
    chk({tag, ".bit_idx"},   32'(bus.bit_idx), 32'(0));
    chk({tag, ".ready"},     32'(bus.ready_led), 32'(mode == M_READY));
    chk({tag, ".done"},      32'(bus.done_led), 32'(mode == M_DONE));
    chk({tag, ".op_count"},  32'(bus.op_count), 32'(mcnt[msel]));
    chk({tag, ".ovf"},       32'(bus.ovf_led), 32'(movf[msel]));
  endtask

  // Called with reset low at posedge+1: releases it and walks the clear.
  task automatic release_seq(input string tag);
    reset = 1'b1;
    for (int k = 0; k < CH; k++) begin
      if (k > 0) tick();
      chk({tag, ".clr_acc"}, 32'(bus.clear_acc), 32'(1));
      chk({tag, ".clr_ch"},  32'(bus.ch_sel), 32'(k));
    end
    tick();
    model_zero();
    msel = 0;
    mode = M_IDLE;
    check_status({tag, ".idle"});
  endtask

  // Entered in the cycle after an accepted load edge.
  task automatic run_op(input string tag, input int tgt, input bit carry);
    chk({tag, ".load"},   32'(bus.load_input), 32'(1));
    chk({tag, ".shift0"}, 32'(bus.shift_en), 32'(0));
    chk({tag, ".ch"},     32'(bus.ch_sel), 32'(tgt));
    msel = tgt;
    for (int b = 0; b < N; b++) begin
      tick();
      chk({tag, ".shift"},  32'(bus.shift_en), 32'(1));
      chk({tag, ".bit"},    32'(bus.bit_idx), 32'(b));
      chk({tag, ".ld_off"}, 32'(bus.load_input), 32'(0));
      chk({tag, ".ch_add"}, 32'(bus.ch_sel), 32'(tgt));
      bus.carry_in = (b == N - 1) ? carry : 1'($urandom);
    end
    tick();
    bus.carry_in = 1'b0;
    if (mcnt[tgt] < (1 << CW) - 1) mcnt[tgt]++;
    if (carry) movf[tgt] = 1'b1;
    mode = (mcnt[tgt] == MAX_OPS) ? M_DONE : M_READY;
  endtask

  // Entered in the first CLEAR cycle after a stop edge in DONE.
  task automatic run_clear(input string tag);
    for (int k = 0; k < CH; k++) begin
      if (k > 0) tick();
      chk({tag, ".clr_acc"}, 32'(bus.clear_acc), 32'(1));
      chk({tag, ".clr_ch"},  32'(bus.ch_sel), 32'(k));
    end
    tick();
    model_zero();
    mode = M_IDLE;
  endtask

  // One cycle of button activity followed through to a settled mode.
  task automatic apply(input string tag, input bit ld, input bit st, input int ch, input bit carry);
    int tgt;
    tgt = (ch < CH) ? ch : 0;
    bus.load_btn  = ld;
    bus.stop_btn  = st;
    bus.ch_sel_in = CHW'(ch);
    tick();
    bus.load_btn = 1'b0;
    bus.stop_btn = 1'b0;
    case (mode)
      M_IDLE: begin
        if (ld && mcnt[tgt] < MAX_OPS) run_op(tag, tgt, carry);
      end
      M_READY: begin
        if (ld) begin
          if (mcnt[tgt] < MAX_OPS) run_op(tag, tgt, carry);
        end else if (st) begin
          mode = M_DONE;
        end
      end
      M_DONE: begin
        if (st) run_clear(tag);
        else if (ld) mode = M_IDLE;
      end
      default: ;
    endcase
    check_status({tag, ".s1"});
    tick();
    check_status({tag, ".s2"});
  endtask

  initial begin
    reset         = 1'b0;
    bus.load_btn  = 1'b1;
    bus.stop_btn  = 1'b0;
    bus.ch_sel_in = '0;
    bus.carry_in  = 1'b0;
    model_zero();
    msel = 0;
    mode = M_CLEAR;

    // Reset values, with load held through reset to create a discarded edge.
    repeat (3) tick();
    chk_reset("rst");
    release_seq("rel");
    bus.load_btn = 1'b0;
    tick();
    check_status("post_rel");

    // Stop ignored in IDLE; first operand on channel 1.
    apply("idle_stop", 1'b0, 1'b1, 0, 1'b0);
    apply("op_ch1",    1'b1, 1'b0, 1, 1'b0);
    // Overflow on channel 0 shows only while channel 0 is selected.
    apply("ovf_ch0",   1'b1, 1'b0, 0, 1'b1);
    apply("sel_ch1",   1'b1, 1'b0, 1, 1'b0);
    // Channel 0 reaches MAX_OPS and finishes without stop.
    apply("ch0_2",     1'b1, 1'b0, 0, 1'b0);
    apply("ch0_3",     1'b1, 1'b0, 0, 1'b0);
    apply("done_ld",   1'b1, 1'b0, 0, 1'b0);
    apply("idle_full", 1'b1, 1'b0, 0, 1'b0);
    apply("ch1_3",     1'b1, 1'b0, 1, 1'b1);
    // Both edges in DONE: stop wins and clears every channel.
    apply("done_both", 1'b1, 1'b1, 0, 1'b0);
    // Both edges in READY: load wins.
    apply("after_clr", 1'b1, 1'b0, 0, 1'b0);
    apply("rdy_both",  1'b1, 1'b1, 1, 1'b1);
    apply("rdy_stop",  1'b0, 1'b1, 0, 1'b0);
    apply("done_idle", 1'b1, 1'b0, 1, 1'b0);

    // Random button traffic.
    for (int i = 0; i < 40; i++) begin
      apply("rnd", ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) == 0),
            int'($urandom_range(CH - 1, 0)), 1'($urandom));
    end

    // Plain reset pulse, then abort an operand with reset at bit 4.
    reset = 1'b0;
    tick();
    chk_reset("rst2");
    release_seq("rel2");
    bus.load_btn  = 1'b1;
    bus.ch_sel_in = CHW'(1);
    tick();
    bus.load_btn = 1'b0;
    chk("abort.load", 32'(bus.load_input), 32'(1));
    repeat (5) tick();
    chk("abort.bit4", 32'(bus.bit_idx), 32'(4));
    reset = 1'b0;
    #1;
    chk_reset("abort");
    tick();
    release_seq("rel3");
    apply("after_abort", 1'b1, 1'b0, 1, 1'b0);
    chk("abort.count", 32'(bus.op_count), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_accum_ctrl.md
# serial_accum_ctrl

Multi-channel, parametrised controller for the serial accumulator datapath. It sequences operand load, N-cycle bit-serial add, and result/done indication for CH independent accumulator channels. It also generates the per-bit shift strobe internally, tracks per-channel operand count and overflow, and performs a staged per-channel clear after reset or on request. It sits between the board buttons and the serial adder/accumulator register bank.

## Interface
- N, 8, operand width in bits = number of serial add cycles per operand (N >= 2)
- CH, 2, number of accumulator channels (CH >= 1)
- MAX_OPS, 15, operands per channel before automatic finish (1..2^CW-1)
- CW, 4, width of per-channel operand counter
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- load_btn  in  1  level button; rising edge requests an operand load
- stop_btn  in  1  level button; rising edge requests finish/clear
- ch_sel_in  in  max(1,$clog2(CH))  target channel, sampled on accepted load edge
- carry_in  in  1  serial adder carry-out, valid while shift_en=1
- ch_sel  out  max(1,$clog2(CH))  channel addressed by datapath
- clear_acc  out  1  clear accumulator of channel ch_sel this cycle
- load_input  out  1  one-cycle operand load strobe
- shift_en  out  1  serial add strobe, high N consecutive cycles
- bit_idx  out  $clog2(N)  current bit (0 = LSB) while shift_en=1, else 0
- op_count  out  CW  operand count of channel ch_sel
- ready_led, done_led  out  1  status
- ovf_led  out  1  sticky overflow flag of channel ch_sel

## Operation
- Button edge detect: prev register per button, reset 0; edge = btn & ~prev. Edges arriving in CLEAR, LOAD, ADD are discarded (not queued).
- States: CLEAR, IDLE, LOAD, ADD, READY, DONE. All outputs decode from registered state/counters (Moore).
- CLEAR: clear_acc=1, ch_sel=clear index k; k counts 0..CH-1, one channel per cycle; op_count[k] and ovf[k] zeroed. After k=CH-1 -> IDLE, k -> 0.
- IDLE: load edge -> LOAD, latch ch_sel_in (values >= CH map to channel 0). Stop edge ignored.
- LOAD: load_input=1 for exactly one cycle -> ADD, bit counter=0.
- ADD: shift_en=1, bit_idx=counter, counter increments each cycle. At bit_idx=N-1: carry_in=1 sets ovf[ch] (sticky); op_count[ch] increments (saturating at 2^CW-1). If the new count == MAX_OPS -> DONE, else -> READY.
- READY: ready_led=1. Load edge -> LOAD (new ch_sel_in latched). Stop edge -> DONE. Both edges in one cycle: load wins. If load targets a channel already at MAX_OPS: ignored, stay READY.
- DONE: done_led=1. Stop edge -> CLEAR (full clear of all channels). Load edge -> IDLE (accumulators and counts retained). Both in same cycle: stop wins.
- IDLE load to a channel at MAX_OPS: ignored, stay IDLE.

## Timing
- Reset (reset=0, async): state=CLEAR, k=0, ch_sel=0, clear_acc=1, load_input=0, shift_en=0, bit_idx=0, all op_count=0, all ovf=0, ready_led=0, done_led=0, ovf_led=0, edge registers 0.
- After reset release: clear_acc high CH cycles, IDLE at cycle CH.
- Load edge sampled at cycle t (in IDLE/READY): LOAD in t+1, ADD t+2..t+N+1, READY/DONE at t+N+2. Load-to-ready latency N+2 cycles.
- A button held through reset produces one edge in the first cycle after release; it falls in CLEAR and is discarded.
- Reset asserted mid-ADD aborts immediately; no count/ovf update for the partial operand.
- ch_sel stable from LOAD through ADD end; changes only in CLEAR or on accepted load.

## Test plan
- Reset with CH=2, release -> clear_acc=1 for 2 cycles with ch_sel 0 then 1, then IDLE, all LEDs 0.
- Load edge, ch_sel_in=1, N=8 -> load_input 1 cycle at t+1, shift_en high 8 cycles, bit_idx 0..7, ready_led at t+10, op_count=1 on ch 1.
- carry_in=1 at bit_idx=7 on ch 0 -> ovf_led=1 while ch_sel=0, 0 after selecting ch 1; cleared only by CLEAR.
- MAX_OPS=3: three loads on ch 0 -> DONE after third ADD without stop; further load to ch 0 from IDLE ignored.
- Load and stop edges same cycle in READY -> LOAD; same in DONE -> CLEAR, counts zeroed.
- reset pulse low during ADD bit 4 -> all outputs at reset values, op_count unchanged-from-zero after CLEAR.
